adc_decimator: RTL and testbench

Boxcar decimator for the comparator-servo ADC path. Consumes the servo voltage word each time the servo loop updates, sums `2**LOG2_RATE` consecutive updates into one full-precision sample, and queues results in a small show-ahead FIFO. Results leave on a valid/ready stream toward the host-side serializer. Sits directly downstream of the servo/DAC loop.

---
 rtl/adc_decimator.sv | 109 ++++++++++
 tb/tb_adc_decimator.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_decimator.sv
// Boxcar decimator: sums 2**LOG2_RATE servo words per output and queues the sums in a
// show-ahead FIFO drained over valid/ready. Optional drop counter: ADC_DECIM_DROP_COUNT_EN.
module adc_decimator #(
    parameter int IN_BITS    = 10,
    parameter int LOG2_RATE  = 6,
    parameter int FIFO_DEPTH = 4,
    localparam int OUT_BITS  = IN_BITS + LOG2_RATE,
    localparam int LVL_BITS  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [IN_BITS-1:0]  sample_in,
    input  logic                sample_en,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LVL_BITS-1:0] fifo_level,
`ifdef ADC_DECIM_DROP_COUNT_EN
    output logic [7:0]          drop_count,
`endif
    output logic                overflow
);

    localparam int PTR_BITS = LVL_BITS - 1;

    logic [OUT_BITS-1:0]  acc;
    logic [LOG2_RATE-1:0] phase;
    logic [OUT_BITS-1:0]  acc_sum;
    logic                 last;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 wr_ok;
    logic                 drop;

    logic [OUT_BITS-1:0]  mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [PTR_BITS-1:0]  rd_ptr;

    assign acc_sum = acc + OUT_BITS'(sample_in);
    assign last    = (phase == {LOG2_RATE{1'b1}});
    assign push    = enable && sample_en && last;
    assign pop     = out_valid && out_ready;
    assign full    = (fifo_level == LVL_BITS'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO only drops when not draining.
    assign wr_ok   = push && (!full || pop);
    assign drop    = push && full && !pop;

    assign out_valid = (fifo_level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            phase <= '0;
        end else if (!enable) begin
            acc   <= '0;
            phase <= '0;
        end else if (sample_en) begin
            if (last) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= acc_sum;
                phase <= phase + LOG2_RATE'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= drop;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            if (wr_ok && !pop) begin
                fifo_level <= fifo_level + LVL_BITS'(1);
            end else if (!wr_ok && pop) begin
                fifo_level <= fifo_level - LVL_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= acc_sum;
        end
    end

`ifdef ADC_DECIM_DROP_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adc_decimator.sv
// Scoreboard bench for adc_decimator: expected sums are queued as windows complete and
// compared when the DUT hands them over on the valid/ready stream.
module tb_adc_decimator;

    localparam int IN_BITS    = 10;
    localparam int LOG2_RATE  = 6;
    localparam int FIFO_DEPTH = 4;
    localparam int OUT_BITS   = IN_BITS + LOG2_RATE;
    localparam int LVL_BITS   = $clog2(FIFO_DEPTH) + 1;
    localparam int RATE       = 1 << LOG2_RATE;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                enable = 1'b0;
    logic [IN_BITS-1:0]  sample_in = '0;
    logic                sample_en = 1'b0;
    logic [OUT_BITS-1:0] out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [LVL_BITS-1:0] fifo_level;
    logic                overflow;
`ifdef ADC_DECIM_DROP_COUNT_EN
    logic [7:0]          drop_count;
`endif

    int errors = 0;
    int checks = 0;
    int ovf_seen = 0;
    int exp_q[$];

    adc_decimator #(
        .IN_BITS   (IN_BITS),
        .LOG2_RATE (LOG2_RATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sample_in (sample_in),
        .sample_en (sample_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_level(fifo_level),
`ifdef ADC_DECIM_DROP_COUNT_EN
        .drop_count(drop_count),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every handshake pops the oldest expected sum.
    always @(negedge clk) begin
        if (!rst && overflow) ovf_seen++;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_unexpected: got %0d, required no output", out_data);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(out_data) !== e) begin
                    errors++;
                    $display("FAIL stream_data: got %0d, required %0d", out_data, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic run_strobes(input int val, input int n);
        for (int i = 0; i < n; i++) begin
            enable    = 1'b1;
            sample_in = IN_BITS'(val);
            sample_en = 1'b1;
            @(posedge clk); #1;
        end
        sample_en = 1'b0;
    endtask

    // One full window of base + i*step; optionally raise out_ready for the last strobe only.
    task automatic run_window(input int base, input int step, input bit push_exp,
                              input bit ready_last);
        int sum;
        sum = 0;
        for (int i = 0; i < RATE; i++) begin
            enable    = 1'b1;
            sample_in = IN_BITS'(base + i * step);
            sum      += base + i * step;
            sample_en = 1'b1;
            if (ready_last && i == RATE - 1) out_ready = 1'b1;
            @(posedge clk); #1;
        end
        sample_en = 1'b0;
        if (push_exp) exp_q.push_back(sum);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== '0 || out_data !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%0b level=%0d data=%0d ovf=%0b, required 0 0 0 0",
                     out_valid, fifo_level, out_data, overflow);
        end
`ifdef ADC_DECIM_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop_count: got %0d, required 0", drop_count);
        end
`endif
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        run_window(512, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd32768) begin
            errors++;
            $display("FAIL single_latency: got valid=%0b data=%0d, required 1 32768",
                     out_valid, out_data);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle: got valid=%0b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        run_window(0, 1, 1'b1, 1'b0);
        checks++;
        if (out_data !== 16'd2016) begin
            errors++;
            $display("FAIL ramp_sum: got %0d, required 2016", out_data);
        end
        run_window(1023, 0, 1'b1, 1'b0);
        checks++;
        if (out_data !== 16'd65472) begin
            errors++;
            $display("FAIL max_sum: got %0d, required 65472", out_data);
        end
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drained: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        int ovf0;
        ovf0 = ovf_seen;
        out_ready = 1'b0;
        for (int w = 0; w < 4; w++) run_window(100, 0, 1'b1, 1'b0);
        checks++;
        if (fifo_level !== LVL_BITS'(4)) begin
            errors++;
            $display("FAIL ovf_level_full: got %0d, required 4", fifo_level);
        end
        run_window(100, 0, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || fifo_level !== LVL_BITS'(4) || out_data !== 16'd6400) begin
            errors++;
            $display("FAIL ovf_pulse: got ovf=%0b level=%0d data=%0d, required 1 4 6400",
                     overflow, fifo_level, out_data);
        end
        @(posedge clk); #1;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_one_cycle: got %0b, required 0", overflow);
        end
`ifdef ADC_DECIM_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'd1) begin
            errors++;
            $display("FAIL drop_count: got %0d, required 1", drop_count);
        end
`endif
        out_ready = 1'b1;
        idle(6);
        checks++;
        if (exp_q.size() != 0 || fifo_level !== '0 || ovf_seen - ovf0 != 1) begin
            errors++;
            $display("FAIL ovf_drain: got pending=%0d level=%0d pulses=%0d, required 0 0 1",
                     exp_q.size(), fifo_level, ovf_seen - ovf0);
        end
    endtask

    task automatic test_full_pop_push();
        int ovf0;
        ovf0 = ovf_seen;
        out_ready = 1'b0;
        for (int w = 1; w <= 4; w++) run_window(w, 0, 1'b1, 1'b0);
        run_window(5, 0, 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b0 || fifo_level !== LVL_BITS'(4)) begin
            errors++;
            $display("FAIL full_pop_push: got ovf=%0b level=%0d, required 0 4",
                     overflow, fifo_level);
        end
        idle(6);
        checks++;
        if (exp_q.size() != 0 || ovf_seen != ovf0) begin
            errors++;
            $display("FAIL full_pop_push_drain: got pending=%0d pulses=%0d, required 0 0",
                     exp_q.size(), ovf_seen - ovf0);
        end
    endtask

    task automatic test_enable();
        out_ready = 1'b1;
        run_strobes(200, 30);
        enable    = 1'b0;
        sample_in = IN_BITS'(999);
        sample_en = 1'b1;
        idle(3);
        sample_en = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_low_quiet: got valid=%0b, required 0", out_valid);
        end
        run_window(10, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd640) begin
            errors++;
            $display("FAIL enable_no_residue: got valid=%0b data=%0d, required 1 640",
                     out_valid, out_data);
        end
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL enable_drained: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        run_window(7, 0, 1'b0, 1'b0);
        run_window(8, 0, 1'b0, 1'b0);
        run_strobes(50, 40);
        checks++;
        if (fifo_level !== LVL_BITS'(2)) begin
            errors++;
            $display("FAIL pre_reset_level: got %0d, required 2", fifo_level);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid=%0b level=%0d data=%0d, required 0 0 0",
                     out_valid, fifo_level, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        run_strobes(3, RATE - 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fresh_window: got valid=%0b after 63 strobes, required 0",
                     out_valid);
        end
        run_strobes(3, 1);
        exp_q.push_back(192);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd192) begin
            errors++;
            $display("FAIL reset_first_sum: got valid=%0b data=%0d, required 1 192",
                     out_valid, out_data);
        end
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_drained: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop_push();
        test_enable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
